// File: rtl/ws2812_frame_serializer.sv
// rtl/ws2812_frame_serializer.sv - WS2812 NRZ frame serializer with latch gap (optional WS2812_GLOBAL_DIM_EN)
module ws2812_frame_serializer #(
  parameter int NUM_LEDS  = 16,
  parameter int T0H_CYC   = 50,
  parameter int T1H_CYC   = 100,
  parameter int BIT_CYC   = 156,
  parameter int RESET_CYC = 6250
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_LEDS*24-1:0]  led_data,
`ifdef WS2812_GLOBAL_DIM_EN
  input  logic [2:0]              dim_shift,
`endif
  output logic                    data_out,
  output logic                    busy,
  output logic                    done
);

  localparam int NUM_BITS = NUM_LEDS * 24;
  localparam int BIDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int CNT_MAX  = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0]  RESET_LAST = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0]  T0H        = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0]  T1H        = CNT_W'(T1H_CYC);
  localparam logic [BIDX_W-1:0] IDX_LAST   = BIDX_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BIT   = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [NUM_BITS-1:0] shadow_q,    shadow_d;
  logic [BIDX_W-1:0]   bit_idx_q,   bit_idx_d;
  logic [CNT_W-1:0]    cyc_cnt_q,   cyc_cnt_d;
  logic                start_prv_q, start_prv_d;
  logic                data_out_q,  data_out_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;

  logic [2:0]          dim_amt;
  logic [NUM_BITS-1:0] frame_wire;
  logic                cur_bit;
  logic [CNT_W-1:0]    th_cyc;
  logic [CNT_W-1:0]    cyc_inc;

`ifdef WS2812_GLOBAL_DIM_EN
  assign dim_amt = dim_shift;
`else
  assign dim_amt = 3'd0;
`endif

  // Reorder the frame into wire order (LED 0 on top, G-R-B per LED) so the
  // shadow register can simply shift out its MSB one bit at a time.
  always_comb begin
    frame_wire = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      frame_wire[(NUM_LEDS-1-i)*24 +: 24] = {
        led_data[i*24 + 8  +: 8] >> dim_amt,
        led_data[i*24 + 16 +: 8] >> dim_amt,
        led_data[i*24      +: 8] >> dim_amt
      };
    end
  end

  assign cur_bit = shadow_q[NUM_BITS-1];
  assign th_cyc  = cur_bit ? T1H : T0H;
  assign cyc_inc = cyc_cnt_q + CNT_W'(1);

  // Next-state logic: launch on a start rising edge in IDLE, time each bit, then hold the latch gap.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    bit_idx_d   = bit_idx_q;
    cyc_cnt_d   = cyc_cnt_q;
    start_prv_d = start;
    data_out_d  = data_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_out_d = 1'b0;
        if (start && !start_prv_q) begin
          shadow_d   = frame_wire;
          bit_idx_d  = '0;
          cyc_cnt_d  = '0;
          busy_d     = 1'b1;
          data_out_d = 1'b1;
          state_d    = S_BIT;
        end
      end
      S_BIT: begin
        if (cyc_cnt_q == BIT_LAST) begin
          cyc_cnt_d = '0;
          if (bit_idx_q == IDX_LAST) begin
            data_out_d = 1'b0;
            state_d    = S_LATCH;
          end else begin
            bit_idx_d  = bit_idx_q + BIDX_W'(1);
            shadow_d   = shadow_q << 1;
            data_out_d = 1'b1;
          end
        end else begin
          cyc_cnt_d  = cyc_inc;
          data_out_d = (cyc_inc < th_cyc);
        end
      end
      S_LATCH: begin
        data_out_d = 1'b0;
        if (cyc_cnt_q == RESET_LAST) begin
          cyc_cnt_d = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cyc_cnt_d = cyc_inc;
        end
      end
      default: begin
        data_out_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      bit_idx_q   <= '0;
      cyc_cnt_q   <= '0;
      start_prv_q <= 1'b0;
      data_out_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      bit_idx_q   <= bit_idx_d;
      cyc_cnt_q   <= cyc_cnt_d;
      start_prv_q <= start_prv_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
